// File: rtl/serializador.sv
// Byte serializer behind the byte queue: pops one byte, shifts it out MSB-first
// under a valid/ready handshake, then idles for a programmable gap.
module serializador #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk_10KHz,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LEN_WIDTH-1:0]  len_in,
    output logic                  dequeue_out,
    input  logic                  ready_in,
    output logic                  serial_out,
    output logic                  serial_valid,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAP_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Handshake: a bit transfers on a rising edge where serial_valid and ready_in are both high.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        dequeue_out  = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b0;
        byte_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (len_in != '0) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                busy        = 1'b1;
                dequeue_out = 1'b1;
                state_d     = S_WAIT;
            end

            // The queue's registered head only shows the popped byte one cycle after the pop.
            S_WAIT: begin
                busy      = 1'b1;
                shift_d   = data_in;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end

            S_SHIFT: begin
                busy         = 1'b1;
                serial_valid = 1'b1;
                serial_out   = shift_q[DATA_WIDTH-1];
                if (ready_in) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
            end

            S_GAP: begin
                busy      = 1'b1;
                byte_done = (gap_cnt_q == '0);
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == LAST_GAP) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: a queue model feeds two instances (gap 1 and gap 4);
// a bit-level scoreboard and timing rules check whichever instance is selected.
module tb_serializador;

    logic       clk = 1'b0;
    always #50 clk = ~clk;

    logic       reset;
    logic [7:0] data_in;
    logic [3:0] len_in;
    logic       ready_in;
    logic       sel;

    logic [3:0] len_a, len_b;
    logic deq_a, so_a, sv_a, busy_a, done_a;
    logic deq_b, so_b, sv_b, busy_b, done_b;
    logic deq, so, sv, bsy, done;

    assign len_a = sel ? 4'd0 : len_in;
    assign len_b = sel ? len_in : 4'd0;
    assign deq   = sel ? deq_b  : deq_a;
    assign so    = sel ? so_b   : so_a;
    assign sv    = sel ? sv_b   : sv_a;
    assign bsy   = sel ? busy_b : busy_a;
    assign done  = sel ? done_b : done_a;

    serializador #(.DATA_WIDTH(8), .LEN_WIDTH(4), .GAP_CYCLES(1)) u_dut_g1 (
        .clk_10KHz(clk), .reset(reset), .data_in(data_in), .len_in(len_a),
        .dequeue_out(deq_a), .ready_in(ready_in), .serial_out(so_a),
        .serial_valid(sv_a), .busy(busy_a), .byte_done(done_a)
    );

    serializador #(.DATA_WIDTH(8), .LEN_WIDTH(4), .GAP_CYCLES(4)) u_dut_g4 (
        .clk_10KHz(clk), .reset(reset), .data_in(data_in), .len_in(len_b),
        .dequeue_out(deq_b), .ready_in(ready_in), .serial_out(so_b),
        .serial_valid(sv_b), .busy(busy_b), .byte_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle", tag, got, exp);
        end
    endtask

    // Reference model: queue contents and the expected serial bit stream.
    logic [7:0] fifo_q[$];
    logic [0:0] exp_q[$];
    int deq_t[$];
    int done_t[$];
    int cyc = 0, deq_cyc = 0, last_acc = 0, done_cyc = -1000, gap = 1, nbits = 0;
    int stall_at = -1, stall_left = 0;
    bit prev_reset = 1'b1, exp_deq = 1'b0, seen_valid = 1'b1, rst_req = 1'b0, rand_ready = 1'b0;

    task automatic step();
        logic [7:0] b;
        @(negedge clk);
        cyc++;
        // Outputs produced by the edge that just happened.
        check("deq_expect", deq, exp_deq);
        check("other_idle", sel ? (deq_a | busy_a) : (deq_b | busy_b), 0);
        check("deq_done_excl", deq & done, 0);
        if (prev_reset) check("reset_outputs", {deq, so, sv, bsy, done}, 0);
        if (!bsy) check("idle_outputs", {so, sv, done}, 0);
        if (deq) begin
            deq_cyc = cyc;
            deq_t.push_back(cyc);
            seen_valid = 1'b0;
            nbits = 0;
        end
        if (sv && !seen_valid) begin
            check("first_bit_latency", cyc - deq_cyc, 2);
            seen_valid = 1'b1;
        end
        if (done) begin
            check("done_latency", cyc - last_acc, 1);
            check("done_bits", nbits, 8);
            done_cyc = cyc;
            done_t.push_back(cyc);
        end
        if (cyc > done_cyc && cyc < done_cyc + gap) check("gap_state", {bsy, sv, done}, 3'b100);
        if (cyc == done_cyc + gap) check("gap_end_idle", bsy, 0);

        // Drive inputs for the next edge.
        if (deq && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            data_in = b;
            for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        end
        len_in = 4'(fifo_q.size());
        reset = rst_req;
        rst_req = 1'b0;
        if (sv && nbits == stall_at && stall_left > 0) begin
            ready_in = 1'b0;
            stall_left--;
        end else begin
            ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end

        // Effects of the upcoming edge.
        if (reset) begin
            exp_q.delete();
            nbits = 0;
            done_cyc = -1000;
            seen_valid = 1'b1;
        end else if (sv && ready_in) begin
            if (exp_q.size() == 0) check("bit_without_byte", 1, 0);
            else check("serial_bit", so, exp_q.pop_front());
            nbits++;
            last_acc = cyc;
        end
        exp_deq = !bsy && (len_in != 0) && !reset;
        prev_reset = reset;
    endtask

    task automatic run_until_idle(input int budget);
        int start;
        start = cyc;
        while (!(fifo_q.size() == 0 && !bsy && !exp_deq && cyc - start > 2)) begin
            if (cyc - start > budget) begin
                check("timeout", 1, 0);
                return;
            end
            step();
        end
        repeat (3) step();
    endtask

    task automatic clear_logs();
        deq_t.delete();
        done_t.delete();
    endtask

    initial begin
        reset = 1'b1; data_in = '0; len_in = '0; ready_in = 1'b1; sel = 1'b0;
        rst_req = 1'b1; step();
        rst_req = 1'b1; step();

        // Empty queue: never a dequeue.
        clear_logs();
        repeat (20) step();
        check("idle_no_deq", deq_t.size(), 0);

        // Single byte A5.
        clear_logs();
        fifo_q.push_back(8'hA5);
        run_until_idle(100);
        check("a5_deq_count", deq_t.size(), 1);
        check("a5_done_count", done_t.size(), 1);
        if (deq_t.size() == 1 && done_t.size() == 1) check("a5_done_time", done_t[0] - deq_t[0], 10);

        // Byte C3 with ready low for 3 cycles while bit 2 is presented.
        clear_logs();
        stall_at = 2; stall_left = 3;
        fifo_q.push_back(8'hC3);
        run_until_idle(100);
        stall_at = -1;
        check("c3_done_count", done_t.size(), 1);
        if (deq_t.size() == 1 && done_t.size() == 1) check("c3_done_time", done_t[0] - deq_t[0], 13);

        // Three back-to-back bytes: dequeues every DATA_WIDTH+GAP+3 cycles.
        clear_logs();
        fifo_q.push_back(8'h01); fifo_q.push_back(8'h80); fifo_q.push_back(8'hFF);
        run_until_idle(200);
        check("b2b_deq_count", deq_t.size(), 3);
        check("b2b_done_count", done_t.size(), 3);
        if (deq_t.size() == 3) begin
            check("b2b_period_1", deq_t[1] - deq_t[0], 12);
            check("b2b_period_2", deq_t[2] - deq_t[1], 12);
        end

        // Reset in the middle of 5A: byte dropped, next byte sent in full.
        clear_logs();
        fifo_q.push_back(8'h5A); fifo_q.push_back(8'h3C);
        for (int i = 0; i < 100 && nbits != 4; i++) step();
        check("mid_reached_bit4", nbits, 4);
        rst_req = 1'b1;
        step();
        run_until_idle(200);
        check("rst_deq_count", deq_t.size(), 2);
        check("rst_done_count", done_t.size(), 1);

        // Gap of 4 cycles.
        sel = 1'b1; gap = 4;
        repeat (3) step();
        clear_logs();
        fifo_q.push_back(8'($urandom)); fifo_q.push_back(8'($urandom));
        run_until_idle(200);
        check("g4_deq_count", deq_t.size(), 2);
        check("g4_done_count", done_t.size(), 2);
        if (deq_t.size() == 2) check("g4_period", deq_t[1] - deq_t[0], 15);

        // Random traffic and random ready on both instances.
        rand_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; gap = s[0] ? 4 : 1;
            repeat (3) step();
            clear_logs();
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 7) == 0 && fifo_q.size() < 15) fifo_q.push_back(8'($urandom));
                step();
            end
            run_until_idle(2000);
            check("rand_deq_vs_done", deq_t.size(), done_t.size());
            check("rand_stream_drained", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
